// File: rtl/alu_entry_sequencer_if.sv
// Button inputs and control outputs of the ALU entry sequencer.
// The sequencer connects through the master modport. The datapath or the
// testbench connects through the slave modport: it drives the buttons and
// observes the strobes and the display controls.
interface alu_entry_sequencer_if;
   logic       enter;
   logic       undo;
   logic       load_a;
   logic       load_b;
   logic       load_op;
   logic       update_res;
   logic [2:0] state;
   logic [3:0] step_led;
   logic       disp_res;
   logic       blink;

   modport master (
      input  enter,
      input  undo,
      output load_a,
      output load_b,
      output load_op,
      output update_res,
      output state,
      output step_led,
      output disp_res,
      output blink
   );

   modport slave (
      output enter,
      output undo,
      input  load_a,
      input  load_b,
      input  load_op,
      input  update_res,
      input  state,
      input  step_led,
      input  disp_res,
      input  blink
   );
endinterface

// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: sequences A, B and OpCode entry for the lab ALU from
// a single enter button. It issues one-cycle load strobes, then a result
// update strobe one cycle after the opcode load, so the combinational ALU has
// time to settle.
// Optional feature: define ALU_SEQ_UNDO_EN to let the undo button step back
// one entry. The default build ignores undo.
// The buttons are level inputs and are already debounced and synchronized.
// Each rising edge counts as one press. The handshake has no ready signal.
module alu_entry_sequencer #(
   parameter int BLINK_DIV = 250
) (
   input logic                  clk,
   input logic                  reset,
   alu_entry_sequencer_if.master bus
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

   typedef enum logic [2:0] {
      S_A    = 3'b000,
      S_B    = 3'b001,
      S_OP   = 3'b010,
      S_CALC = 3'b011,
      S_RES  = 3'b100
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          enter_q;
   logic          enter_rise;
   logic          undo_rise;
   logic          load_a_q;
   logic          load_b_q;
   logic          load_op_q;
   logic          update_res_q;
   logic          load_a_d;
   logic          load_b_d;
   logic          load_op_d;
   logic          update_res_d;
   logic [CW-1:0] cnt_q;
   logic          blink_q;
   logic          editing;
   logic [3:0]    step_led_d;
   logic          disp_res_d;

   // Previous enter level. It resets high, so an enter button held through
   // reset produces no edge.
   always_ff @(posedge clk) begin
      if (reset) enter_q <= 1'b1;
      else       enter_q <= bus.enter;
   end

   assign enter_rise = bus.enter & ~enter_q;

`ifdef ALU_SEQ_UNDO_EN
   logic undo_q;

   // Previous undo level. It resets high for the same reason as enter_q.
   always_ff @(posedge clk) begin
      if (reset) undo_q <= 1'b1;
      else       undo_q <= bus.undo;
   end

   assign undo_rise = bus.undo & ~undo_q;
`else
   logic unused_undo;
   assign unused_undo = bus.undo;
   assign undo_rise   = 1'b0;
`endif

   // Next state and next strobe values. Enter has priority over undo. S_CALC
   // always advances after one cycle and ignores both buttons.
   always_comb begin
      state_d      = state_q;
      load_a_d     = 1'b0;
      load_b_d     = 1'b0;
      load_op_d    = 1'b0;
      update_res_d = 1'b0;
      case (state_q)
         S_A: begin
            if (enter_rise) begin
               state_d  = S_B;
               load_a_d = 1'b1;
            end
         end
         S_B: begin
            if (enter_rise) begin
               state_d  = S_OP;
               load_b_d = 1'b1;
            end else if (undo_rise) begin
               state_d = S_A;
            end
         end
         S_OP: begin
            if (enter_rise) begin
               state_d   = S_CALC;
               load_op_d = 1'b1;
            end else if (undo_rise) begin
               state_d = S_B;
            end
         end
         S_CALC: begin
            state_d      = S_RES;
            update_res_d = 1'b1;
         end
         S_RES: begin
            if (enter_rise) begin
               state_d = S_A;
            end else if (undo_rise) begin
               state_d = S_OP;
            end
         end
         default: begin
            state_d = S_A;
         end
      endcase
   end

   // State register and registered strobes. Reset suppresses a strobe that
   // would otherwise fire on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_A;
         load_a_q     <= 1'b0;
         load_b_q     <= 1'b0;
         load_op_q    <= 1'b0;
         update_res_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_a_q     <= load_a_d;
         load_b_q     <= load_b_d;
         load_op_q    <= load_op_d;
         update_res_q <= update_res_d;
      end
   end

   assign editing = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);

   // Blink generator. It runs only while an entry is being edited. Any state
   // change restarts it with the display on.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         blink_q <= 1'b1;
      end else if ((state_d != state_q) || !editing) begin
         cnt_q   <= '0;
         blink_q <= 1'b1;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q   <= '0;
         blink_q <= ~blink_q;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Decode the step indicator and the display source from the current state.
   always_comb begin
      step_led_d = 4'b0001;
      disp_res_d = 1'b0;
      case (state_q)
         S_A:     step_led_d = 4'b0001;
         S_B:     step_led_d = 4'b0010;
         S_OP:    step_led_d = 4'b0100;
         S_CALC: begin
            step_led_d = 4'b1000;
            disp_res_d = 1'b1;
         end
         S_RES: begin
            step_led_d = 4'b1000;
            disp_res_d = 1'b1;
         end
         default: begin
            step_led_d = 4'b0001;
            disp_res_d = 1'b0;
         end
      endcase
   end

   assign bus.load_a     = load_a_q;
   assign bus.load_b     = load_b_q;
   assign bus.load_op    = load_op_q;
   assign bus.update_res = update_res_q;
   assign bus.state      = state_q;
   assign bus.step_led   = step_led_d;
   assign bus.disp_res   = disp_res_d;
   assign bus.blink      = blink_q;

endmodule
